// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for configurable routing blocks (connection block,
// switch box): configuration FSM states, source/track code constants and
// the sizing functions that derive mux select widths and bitstream length
// from the block parameters.
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

    // Configuration chain states
    typedef enum logic [1:0] {
        ST_UNCONF   = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_ACTIVE   = 2'd2
    } cfg_state_e;

    // Input-mux code 0 always selects a constant zero
    localparam int SRC_CODE_ZERO = 0;
    // Track-driver code 0 always passes the incoming track through
    localparam int TRK_CODE_PASS = 0;

    // Ceiling log2; returns 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of input-mux sources: zero, singles, doubles, globals, opposite CLB
    function automatic int src_count(input int ws, input int wd, input int wg,
                                     input int clbx, input int clbout);
        return 1 + ws + wd + wg + clbx * clbout;
    endfunction

    function automatic int sel_in_bits(input int ws, input int wd, input int wg,
                                       input int clbx, input int clbout);
        return clog2(src_count(ws, wd, wg, clbx, clbout));
    endfunction

    // Track code space: pass-through plus every output of both CLBs
    function automatic int sel_trk_bits(input int clbout);
        return clog2(1 + 2 * clbout);
    endfunction

    function automatic int cfg_bits(input int ws, input int wd, input int wg,
                                    input int clbin, input int clbout, input int clbx);
        return 2 * clbin * sel_in_bits(ws, wd, wg, clbx, clbout)
             + (ws + wd) * sel_trk_bits(clbout);
    endfunction

endpackage

// File: rtl/connection_block_cfg_if.sv
// ---------------------------------------------------------------------------
// connection_block_cfg_if
// Bundles the routing and configuration signals of the connection block.
//   master : the surroundings (switch boxes, CLBs, config controller)
//   slave  : the connection block itself
// Tracks: single_in/out, double_in/out, global0
// CLB side: clb{0,1}_output, clb{0,1}_cout (into block),
//           clb{0,1}_input, clb{0,1}_cin (out of block)
// Config: cfg_in, cfg_shift, cfg_commit, cfg_capture (into block),
//         cfg_out, cfg_valid, cfg_err (out of block)
// ---------------------------------------------------------------------------
interface connection_block_cfg_if #(
    parameter int WS     = 8,
    parameter int WD     = 8,
    parameter int WG     = 3,
    parameter int CLBIN  = 6,
    parameter int CLBOUT = 1,
    parameter int CARRY  = 1
) ();

    logic [WS-1:0]     single_in;
    logic [WS-1:0]     single_out;
    logic [WD-1:0]     double_in;
    logic [WD-1:0]     double_out;
    logic [WG-1:0]     global0;
    logic [CLBOUT-1:0] clb0_output;
    logic [CLBOUT-1:0] clb1_output;
    logic [CARRY-1:0]  clb0_cout;
    logic [CARRY-1:0]  clb1_cout;
    logic [CLBIN-1:0]  clb0_input;
    logic [CLBIN-1:0]  clb1_input;
    logic [CARRY-1:0]  clb0_cin;
    logic [CARRY-1:0]  clb1_cin;
    logic              cfg_in;
    logic              cfg_shift;
    logic              cfg_commit;
    logic              cfg_capture;
    logic              cfg_out;
    logic              cfg_valid;
    logic              cfg_err;

    modport master (
        output single_in, double_in, global0, clb0_output, clb1_output,
               clb0_cout, clb1_cout, cfg_in, cfg_shift, cfg_commit, cfg_capture,
        input  single_out, double_out, clb0_input, clb1_input, clb0_cin, clb1_cin,
               cfg_out, cfg_valid, cfg_err
    );

    modport slave (
        input  single_in, double_in, global0, clb0_output, clb1_output,
               clb0_cout, clb1_cout, cfg_in, cfg_shift, cfg_commit, cfg_capture,
        output single_out, double_out, clb0_input, clb1_input, clb0_cin, clb1_cin,
               cfg_out, cfg_valid, cfg_err
    );

endinterface

// File: rtl/cfg_chain.sv
// ---------------------------------------------------------------------------
// cfg_chain
// Serial configuration chain with shadow/active registers. Bits shift in
// at the MSB end and leave at bit 0 (cfg_out). A commit copies the shadow
// into the active register only when exactly CFG_BITS bits were shifted;
// otherwise a sticky error is raised and the active config is kept.
// Priority per cycle: commit > shift > capture.
// Optional: CONNECTION_BLOCK_CFG_READBACK_EN enables cfg_capture, which
// loads the active config into the shadow so it can be shifted out.
// Ports:
//   clk, rst (sync, active-high)
//   cfg_in, cfg_shift, cfg_commit, cfg_capture : chain control
//   cfg_out  : chain tail (shreg[0])
//   cfg_valid: active config holds a committed bitstream
//   cfg_err  : sticky length error, cleared only by rst
//   active   : active configuration word
// ---------------------------------------------------------------------------
module cfg_chain
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_in,
    input  logic                cfg_shift,
    input  logic                cfg_commit,
    input  logic                cfg_capture,
    output logic                cfg_out,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic [CFG_BITS-1:0] active
);

    // Counter must reach CFG_BITS+1 so over-length loads stay distinguishable
    localparam int CNT_W = clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    cfg_state_e          state_r;
    cfg_state_e          state_s;
    logic [CFG_BITS-1:0] shreg_r;
    logic [CFG_BITS-1:0] active_r;
    logic [CNT_W-1:0]    count_r;
    logic                valid_r;
    logic                err_r;
    logic                commit_ok_s;
    logic                capture_s;

`ifdef CONNECTION_BLOCK_CFG_READBACK_EN
    assign capture_s = cfg_capture;
`else
    logic capture_unused_s;
    assign capture_unused_s = cfg_capture;
    assign capture_s        = 1'b0;
`endif

    assign commit_ok_s = cfg_commit && (count_r == CNT_FULL);

    // Next-state logic: commit dominates, a failed commit falls back to
    // whichever state matches the (unchanged) validity of the active config
    always_comb begin
        state_s = state_r;
        if (cfg_commit) begin
            if (commit_ok_s || valid_r) begin
                state_s = ST_ACTIVE;
            end else begin
                state_s = ST_UNCONF;
            end
        end else if (cfg_shift) begin
            state_s = ST_SHIFTING;
        end else begin
            state_s = state_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_UNCONF;
        end else begin
            state_r <= state_s;
        end
    end

    // Shadow, counter, active register and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r  <= '0;
            active_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else if (cfg_commit) begin
            count_r <= '0;
            if (commit_ok_s) begin
                active_r <= shreg_r;
                valid_r  <= 1'b1;
            end else begin
                err_r <= 1'b1;
            end
        end else if (cfg_shift) begin
            shreg_r <= {cfg_in, shreg_r[CFG_BITS-1:1]};
            if (count_r != CNT_SAT) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (capture_s) begin
            shreg_r <= active_r;
            count_r <= '0;
        end
    end

    assign cfg_out   = shreg_r[0];
    assign cfg_valid = valid_r;
    assign cfg_err   = err_r;
    assign active    = active_r;

endmodule

// File: rtl/connection_block_cfg.sv
// ---------------------------------------------------------------------------
// connection_block_cfg
// Unidirectional connection block between two CLBs and a single/double/
// global track bundle. Each CLB input is a mux over {0, singles, doubles,
// globals, opposite-CLB outputs}; each single/double track is either passed
// through or driven by a CLB output. Carry wiring is fixed by CARRYTYPE.
// Routing is combinational from the active config held in cfg_chain.
// Bitstream layout, LSB first: clb0 input selects, clb1 input selects,
// single track codes, double track codes.
// Optional: CONNECTION_BLOCK_CFG_READBACK_EN enables config readback via
// cfg_capture (see cfg_chain).
// Ports:
//   clk, rst (sync, active-high)
//   bus : connection_block_cfg_if.slave (tracks, CLB pins, config chain)
// The interface instance must be built with the same WS/WD/WG/CLBIN/
// CLBOUT/CARRY values as this module.
// ---------------------------------------------------------------------------
module connection_block_cfg
    import fpga_cfg_pkg::*;
#(
    parameter int         WS        = 8,
    parameter int         WD        = 8,
    parameter int         WG        = 3,
    parameter int         CLBIN     = 6,
    parameter int         CLBOUT    = 1,
    parameter int         CARRY     = 1,
    parameter logic [1:0] CARRYTYPE = 2'd2,
    parameter int         CLBX      = 1
) (
    input logic                  clk,
    input logic                  rst,
    connection_block_cfg_if.slave bus
);

    localparam int SRC      = src_count(WS, WD, WG, CLBX, CLBOUT);
    localparam int SEL_IN   = sel_in_bits(WS, WD, WG, CLBX, CLBOUT);
    localparam int SEL_TRK  = sel_trk_bits(CLBOUT);
    localparam int CFG_BITS = cfg_bits(WS, WD, WG, CLBIN, CLBOUT, CLBX);
    localparam int OFS_CLB1 = CLBIN * SEL_IN;
    localparam int OFS_SGL  = 2 * CLBIN * SEL_IN;
    localparam int OFS_DBL  = OFS_SGL + WS * SEL_TRK;
    localparam int NDRV     = 1 + 2 * CLBOUT;

    logic [CFG_BITS-1:0] active_s;
    logic [SRC-1:0]      src0_s;
    logic [SRC-1:0]      src1_s;
    logic [CLBIN-1:0]    clb0_in_s;
    logic [CLBIN-1:0]    clb1_in_s;
    logic [WS-1:0]       single_out_s;
    logic [WD-1:0]       double_out_s;
    logic                cfg_out_s;
    logic                cfg_valid_s;
    logic                cfg_err_s;

    // Input-mux select: codes at or beyond SRC drive zero
    function automatic logic pick_src(input logic [SRC-1:0] src,
                                      input logic [SEL_IN-1:0] code);
        if (int'(code) == SRC_CODE_ZERO) begin
            return 1'b0;
        end else if (int'(code) < SRC) begin
            return src[code];
        end else begin
            return 1'b0;
        end
    endfunction

    // Track driver: drv = {clb1_output, clb0_output, pass}; unused codes pass
    function automatic logic drive_trk(input logic [NDRV-1:0] drv,
                                       input logic [SEL_TRK-1:0] code);
        if (int'(code) == TRK_CODE_PASS) begin
            return drv[0];
        end else if (int'(code) < NDRV) begin
            return drv[code];
        end else begin
            return drv[0];
        end
    endfunction

    cfg_chain #(
        .CFG_BITS (CFG_BITS)
    ) u_cfg_chain (
        .clk         (clk),
        .rst         (rst),
        .cfg_in      (bus.cfg_in),
        .cfg_shift   (bus.cfg_shift),
        .cfg_commit  (bus.cfg_commit),
        .cfg_capture (bus.cfg_capture),
        .cfg_out     (cfg_out_s),
        .cfg_valid   (cfg_valid_s),
        .cfg_err     (cfg_err_s),
        .active      (active_s)
    );

    // Source vectors, index == mux code; each CLB sees the other's outputs
    if (CLBX != 0) begin : g_opp
        assign src0_s = {bus.clb1_output, bus.global0, bus.double_in, bus.single_in, 1'b0};
        assign src1_s = {bus.clb0_output, bus.global0, bus.double_in, bus.single_in, 1'b0};
    end else begin : g_no_opp
        assign src0_s = {bus.global0, bus.double_in, bus.single_in, 1'b0};
        assign src1_s = {bus.global0, bus.double_in, bus.single_in, 1'b0};
    end

    for (genvar j = 0; j < CLBIN; j++) begin : g_clb_in
        assign clb0_in_s[j] = pick_src(src0_s, active_s[j*SEL_IN +: SEL_IN]);
        assign clb1_in_s[j] = pick_src(src1_s, active_s[OFS_CLB1 + j*SEL_IN +: SEL_IN]);
    end

    for (genvar i = 0; i < WS; i++) begin : g_sgl
        assign single_out_s[i] = drive_trk({bus.clb1_output, bus.clb0_output, bus.single_in[i]},
                                           active_s[OFS_SGL + i*SEL_TRK +: SEL_TRK]);
    end

    for (genvar i = 0; i < WD; i++) begin : g_dbl
        assign double_out_s[i] = drive_trk({bus.clb1_output, bus.clb0_output, bus.double_in[i]},
                                           active_s[OFS_DBL + i*SEL_TRK +: SEL_TRK]);
    end

    assign bus.clb0_input = clb0_in_s;
    assign bus.clb1_input = clb1_in_s;
    assign bus.single_out = single_out_s;
    assign bus.double_out = double_out_s;
    assign bus.clb1_cin   = CARRYTYPE[0] ? bus.clb0_cout : {CARRY{1'b0}};
    assign bus.clb0_cin   = CARRYTYPE[1] ? bus.clb1_cout : {CARRY{1'b0}};
    assign bus.cfg_out    = cfg_out_s;
    assign bus.cfg_valid  = cfg_valid_s;
    assign bus.cfg_err    = cfg_err_s;

endmodule

// File: tb/tb_connection_block_cfg.sv
// ---------------------------------------------------------------------------
// tb_connection_block_cfg
// Directed bench for connection_block_cfg with default parameters
// (CFG_BITS = 92, 5-bit input selects, 2-bit track codes). Stimulus pushes
// expected observations into a queue; a monitor on the falling edge pops
// and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_connection_block_cfg;

    localparam int CFG_BITS = 92;
    localparam int SEL_IN   = 5;
    localparam int SEL_TRK  = 2;
    localparam int OFS_CLB1 = 30;
    localparam int OFS_SGL  = 60;
    localparam int OFS_DBL  = 76;

    typedef enum int {
        O_VALID, O_ERR, O_CFG_OUT, O_CLB0_IN, O_CLB1_IN,
        O_SGL_OUT, O_DBL_OUT, O_CIN0, O_CIN1
    } obs_e;

    typedef struct {
        obs_e        id;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst;

    logic [CFG_BITS-1:0] cfg_a;
    logic [CFG_BITS-1:0] cfg_b;
    logic [CFG_BITS-1:0] pat;

    always #5 clk = ~clk;

    connection_block_cfg_if bus ();

    connection_block_cfg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] observe(input obs_e id);
        case (id)
            O_VALID:   return {31'd0, bus.cfg_valid};
            O_ERR:     return {31'd0, bus.cfg_err};
            O_CFG_OUT: return {31'd0, bus.cfg_out};
            O_CLB0_IN: return {26'd0, bus.clb0_input};
            O_CLB1_IN: return {26'd0, bus.clb1_input};
            O_SGL_OUT: return {24'd0, bus.single_out};
            O_DBL_OUT: return {24'd0, bus.double_out};
            O_CIN0:    return {31'd0, bus.clb0_cin};
            O_CIN1:    return {31'd0, bus.clb1_cin};
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Scoreboard monitor: compare everything queued since the last falling edge
    always @(negedge clk) begin
        exp_t        it;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = observe(it.id);
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", it.tag, act, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input obs_e id, input logic [31:0] v, input string tag);
        exp_t it;
        it.id  = id;
        it.exp = v;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    task automatic check_now();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [7:0] s, input logic [7:0] d, input logic [2:0] g,
                            input logic o0, input logic o1);
        bus.single_in   = s;
        bus.double_in   = d;
        bus.global0     = g;
        bus.clb0_output = o0;
        bus.clb1_output = o1;
    endtask

    task automatic shift_bits(input logic [CFG_BITS-1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            bus.cfg_in    = v[k];
            bus.cfg_shift = 1'b1;
            tick();
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
    endtask

    task automatic commit();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    function automatic logic [CFG_BITS-1:0] put(input logic [CFG_BITS-1:0] v, input int lsb,
                                                input int w, input int code);
        logic [CFG_BITS-1:0] r;
        r = v;
        for (int b = 0; b < w; b++) begin
            r[lsb + b] = code[b];
        end
        return r;
    endfunction

    initial begin
        // Config A: varied sources on both CLBs and a few track drivers
        cfg_a = '0;
        cfg_a = put(cfg_a, 0 * SEL_IN, SEL_IN, 1);              // clb0 in0 <- single[0]
        cfg_a = put(cfg_a, 1 * SEL_IN, SEL_IN, 9);              // clb0 in1 <- double[0]
        cfg_a = put(cfg_a, 2 * SEL_IN, SEL_IN, 17);             // clb0 in2 <- global[0]
        cfg_a = put(cfg_a, 3 * SEL_IN, SEL_IN, 20);             // clb0 in3 <- clb1_output
        cfg_a = put(cfg_a, 4 * SEL_IN, SEL_IN, 25);             // clb0 in4 out of range -> 0
        cfg_a = put(cfg_a, OFS_CLB1 + 0 * SEL_IN, SEL_IN, 20);  // clb1 in0 <- clb0_output
        cfg_a = put(cfg_a, OFS_CLB1 + 5 * SEL_IN, SEL_IN, 8);   // clb1 in5 <- single[7]
        cfg_a = put(cfg_a, OFS_SGL + 3 * SEL_TRK, SEL_TRK, 1);  // single[3] <- clb0_output
        cfg_a = put(cfg_a, OFS_SGL + 6 * SEL_TRK, SEL_TRK, 3);  // single[6] code 3 -> pass
        cfg_a = put(cfg_a, OFS_DBL + 5 * SEL_TRK, SEL_TRK, 2);  // double[5] <- clb1_output
        // Config B: clb0 in0 <- single[1], single[0] <- clb1_output
        cfg_b = '0;
        cfg_b = put(cfg_b, 0, SEL_IN, 2);
        cfg_b = put(cfg_b, OFS_SGL, SEL_TRK, 2);
        pat = {23{4'hA}};

        rst             = 1'b1;
        bus.cfg_in      = 1'b0;
        bus.cfg_shift   = 1'b0;
        bus.cfg_commit  = 1'b0;
        bus.cfg_capture = 1'b0;
        bus.clb0_cout   = 1'b1;
        bus.clb1_cout   = 1'b1;
        set_pins(8'hA5, 8'h3C, 3'b101, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state and static carry wiring (CARRYTYPE = 2)
        expect_out(O_VALID,   32'd0,    "rst_valid");
        expect_out(O_ERR,     32'd0,    "rst_err");
        expect_out(O_CFG_OUT, 32'd0,    "rst_cfg_out");
        expect_out(O_CLB0_IN, 32'd0,    "rst_clb0_in");
        expect_out(O_CLB1_IN, 32'd0,    "rst_clb1_in");
        expect_out(O_SGL_OUT, 32'hA5,   "rst_single_pass");
        expect_out(O_DBL_OUT, 32'h3C,   "rst_double_pass");
        expect_out(O_CIN0,    32'd1,    "carry_cin0_from_clb1");
        expect_out(O_CIN1,    32'd0,    "carry_cin1_disabled");
        check_now();
        checks++;
        if (bus.cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL direct_rst_valid: actual=%b required=0", bus.cfg_valid);
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL direct_rst_err: actual=%b required=0", bus.cfg_err);
        end
        checks++;
        if (bus.clb0_input !== 6'd0) begin
            errors++;
            $display("FAIL direct_rst_clb0_in: actual=%h required=0", bus.clb0_input);
        end
        bus.clb0_cout = 1'b1;
        bus.clb1_cout = 1'b0;
        expect_out(O_CIN0,    32'd0,    "carry_cin0_follow");
        expect_out(O_CIN1,    32'd0,    "carry_cin1_still_zero");
        check_now();

        // Full load of A: nothing visible until commit
        shift_bits(cfg_a, CFG_BITS);
        expect_out(O_VALID,   32'd0,    "preload_valid");
        expect_out(O_CLB0_IN, 32'd0,    "preload_clb0_in");
        check_now();
        commit();

        set_pins(8'h01, 8'h00, 3'b000, 1'b0, 1'b0);
        expect_out(O_VALID,   32'd1,    "a_valid");
        expect_out(O_ERR,     32'd0,    "a_err");
        expect_out(O_CLB0_IN, 32'h01,   "a_p1_clb0_in");
        expect_out(O_CLB1_IN, 32'h00,   "a_p1_clb1_in");
        expect_out(O_SGL_OUT, 32'h01,   "a_p1_single_out");
        expect_out(O_DBL_OUT, 32'h00,   "a_p1_double_out");
        check_now();
        checks++;
        if (bus.cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL direct_a_valid: actual=%b required=1", bus.cfg_valid);
        end

        set_pins(8'hF6, 8'h01, 3'b001, 1'b1, 1'b1);
        expect_out(O_CLB0_IN, 32'h0E,   "a_p2_clb0_in");
        expect_out(O_CLB1_IN, 32'h21,   "a_p2_clb1_in");
        expect_out(O_SGL_OUT, 32'hFE,   "a_p2_single_out");
        expect_out(O_DBL_OUT, 32'h21,   "a_p2_double_out");
        check_now();

        set_pins(8'h00, 8'hFF, 3'b110, 1'b1, 1'b0);
        expect_out(O_CLB0_IN, 32'h02,   "a_p3_clb0_in");
        expect_out(O_CLB1_IN, 32'h01,   "a_p3_clb1_in");
        expect_out(O_SGL_OUT, 32'h08,   "a_p3_single_out");
        expect_out(O_DBL_OUT, 32'hDF,   "a_p3_double_out");
        check_now();

        // Commit and shift in the same cycle: commit wins, shift dropped
        shift_bits(cfg_b, CFG_BITS);
        bus.cfg_commit = 1'b1;
        bus.cfg_shift  = 1'b1;
        bus.cfg_in     = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        bus.cfg_shift  = 1'b0;
        bus.cfg_in     = 1'b0;
        set_pins(8'h02, 8'h00, 3'b000, 1'b0, 1'b1);
        expect_out(O_VALID,   32'd1,    "prio_valid");
        expect_out(O_ERR,     32'd0,    "prio_err");
        expect_out(O_CLB0_IN, 32'h01,   "prio_clb0_in");
        expect_out(O_CLB1_IN, 32'h00,   "prio_clb1_in");
        expect_out(O_SGL_OUT, 32'h03,   "prio_single_out");
        check_now();

        // Counter restarted at 0: a fresh full load of A must commit
        shift_bits(cfg_a, CFG_BITS);
        commit();
        set_pins(8'h01, 8'h00, 3'b000, 1'b0, 1'b0);
        expect_out(O_ERR,     32'd0,    "reload_err");
        expect_out(O_CLB0_IN, 32'h01,   "reload_clb0_in");
        expect_out(O_SGL_OUT, 32'h01,   "reload_single_out");
        check_now();

        // Short load while ACTIVE: routing stable, then length error on commit
        set_pins(8'h00, 8'hFF, 3'b110, 1'b1, 1'b0);
        for (int k = 0; k < CFG_BITS - 1; k++) begin
            bus.cfg_in    = cfg_b[k];
            bus.cfg_shift = 1'b1;
            tick();
            if (k == 45) begin
                expect_out(O_VALID,   32'd1,  "midshift_valid");
                expect_out(O_CLB0_IN, 32'h02, "midshift_clb0_in");
                expect_out(O_SGL_OUT, 32'h08, "midshift_single_out");
                check_now();
            end
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
        commit();
        expect_out(O_ERR,     32'd1,    "short_err");
        expect_out(O_VALID,   32'd1,    "short_valid");
        expect_out(O_CLB0_IN, 32'h02,   "short_clb0_in");
        expect_out(O_CLB1_IN, 32'h01,   "short_clb1_in");
        expect_out(O_SGL_OUT, 32'h08,   "short_single_out");
        expect_out(O_DBL_OUT, 32'hDF,   "short_double_out");
        check_now();

        // Shadow holds a known pattern; then try a capture
        shift_bits(pat, CFG_BITS);
        expect_out(O_CFG_OUT, {31'd0, pat[0]}, "pat_tail");
        check_now();
        bus.cfg_capture = 1'b1;
        tick();
        bus.cfg_capture = 1'b0;
`ifdef CONNECTION_BLOCK_CFG_READBACK_EN
        for (int k = 0; k < CFG_BITS; k++) begin
            expect_out(O_CFG_OUT, {31'd0, cfg_a[k]}, "readback_bit");
            check_now();
            bus.cfg_in    = 1'b0;
            bus.cfg_shift = 1'b1;
            tick();
            bus.cfg_shift = 1'b0;
        end
        expect_out(O_VALID,   32'd1,    "readback_valid");
        expect_out(O_CLB0_IN, 32'h02,   "readback_clb0_in");
        check_now();
`else
        for (int k = 0; k < 4; k++) begin
            expect_out(O_CFG_OUT, {31'd0, pat[k]}, "nocapture_tail");
            check_now();
            bus.cfg_in    = 1'b0;
            bus.cfg_shift = 1'b1;
            tick();
            bus.cfg_shift = 1'b0;
        end
`endif

        // Reset in the middle of a shift discards everything
        set_pins(8'h5A, 8'h00, 3'b000, 1'b1, 1'b1);
        shift_bits(pat, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out(O_VALID,   32'd0,    "midrst_valid");
        expect_out(O_ERR,     32'd0,    "midrst_err");
        expect_out(O_CLB0_IN, 32'd0,    "midrst_clb0_in");
        expect_out(O_CLB1_IN, 32'd0,    "midrst_clb1_in");
        expect_out(O_SGL_OUT, 32'h5A,   "midrst_single_pass");
        expect_out(O_CFG_OUT, 32'd0,    "midrst_cfg_out");
        check_now();

        tick();
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
